// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU results and buffered slow-unit results onto the register bank write port
// Optional build macro WB_ARBITER_STATS_EN adds a saturating stall_count output.
module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic        clk,
  input  logic        reset,
`ifdef WB_ARBITER_STATS_EN
  output logic [31:0] stall_count,
`endif
  input  logic        alu_valid,
  input  logic [3:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        alu_high,
  output logic        alu_stall,
  input  logic        mu_valid,
  output logic        mu_ready,
  input  logic [3:0]  mu_addr,
  input  logic [31:0] mu_data,
  input  logic [3:0]  addr_a,
  input  logic [3:0]  addr_b,
  output logic        pending_a,
  output logic        pending_b,
  output logic [3:0]  addr_d,
  output logic [31:0] data_d,
  output logic        we,
  output logic        we_high
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [3:0]       r_fifo_addr [DEPTH];
  logic [31:0]      r_fifo_data [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic [DEPTH-1:0] w_valid;
  logic [PTR_W-1:0] w_off;
  logic             w_hit_a, w_hit_b, w_waw, w_full, w_sel_fifo, w_push, w_pop;

  // Occupancy of each slot relative to the head, and address matches against live entries
  always_comb begin
    w_valid = '0;
    w_off = '0;
    w_hit_a = 1'b0;
    w_hit_b = 1'b0;
    w_waw = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PTR_W'(i) - r_rd_ptr;
      w_valid[i] = {1'b0, w_off} < r_count;
      w_hit_a = w_hit_a | (w_valid[i] && r_fifo_addr[i] == addr_a);
      w_hit_b = w_hit_b | (w_valid[i] && r_fifo_addr[i] == addr_b);
      w_waw = w_waw | (w_valid[i] && r_fifo_addr[i] == alu_addr);
    end
  end

  assign w_full     = r_count == FULL;
  assign mu_ready   = !w_full;
  assign w_push     = mu_valid && mu_ready;
  assign w_sel_fifo = r_count != '0 && (!alu_valid || w_full || (alu_addr != 4'd0 && w_waw));
  assign w_pop      = w_sel_fifo;
  assign alu_stall  = alu_valid && w_sel_fifo;
  assign pending_a  = addr_a != 4'd0 && w_hit_a;
  assign pending_b  = addr_b != 4'd0 && w_hit_b;

  // FIFO storage; slots are only meaningful while counted, so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= mu_addr;
      r_fifo_data[r_wr_ptr] <= mu_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

  // Bank write register; r0 writes are consumed but never enabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_d <= '0;
      data_d <= '0;
      we <= 1'b0;
      we_high <= 1'b0;
    end else if (w_sel_fifo) begin
      addr_d <= r_fifo_addr[r_rd_ptr];
      data_d <= r_fifo_data[r_rd_ptr];
      we <= r_fifo_addr[r_rd_ptr] != 4'd0;
      we_high <= 1'b0;
    end else if (alu_valid) begin
      addr_d <= alu_addr;
      data_d <= alu_data;
      we <= alu_addr != 4'd0;
      we_high <= alu_high;
    end else begin
      we <= 1'b0;
    end
  end

`ifdef WB_ARBITER_STATS_EN
  logic [31:0] r_stall_count;

  // Saturating count of cycles in which the ALU result was held back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_stall_count <= '0;
    else if (alu_stall && r_stall_count != 32'hFFFF_FFFF) r_stall_count <= r_stall_count + 32'd1;
  end

  assign stall_count = r_stall_count;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0, alu_high = 1'b0, mu_valid = 1'b0;
  logic [3:0]  alu_addr = '0, mu_addr = '0, addr_a = '0, addr_b = '0;
  logic [31:0] alu_data = '0, mu_data = '0;
  logic        alu_stall, mu_ready, pending_a, pending_b, we, we_high;
  logic [3:0]  addr_d;
  logic [31:0] data_d;
`ifdef WB_ARBITER_STATS_EN
  logic [31:0] stall_count;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  wb_arbiter #(.DEPTH(2), .PTR_W(1)) dut (
    .clk(clk),
    .reset(reset),
`ifdef WB_ARBITER_STATS_EN
    .stall_count(stall_count),
`endif
    .alu_valid(alu_valid),
    .alu_addr(alu_addr),
    .alu_data(alu_data),
    .alu_high(alu_high),
    .alu_stall(alu_stall),
    .mu_valid(mu_valid),
    .mu_ready(mu_ready),
    .mu_addr(mu_addr),
    .mu_data(mu_data),
    .addr_a(addr_a),
    .addr_b(addr_b),
    .pending_a(pending_a),
    .pending_b(pending_b),
    .addr_d(addr_d),
    .data_d(data_d),
    .we(we),
    .we_high(we_high)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick;
    tick;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", 32'(addr_d), 32'd0);
    chk("rst_ready", 32'(mu_ready), 32'd1);
    chk("rst_pend", 32'(pending_a), 32'd0);
    reset = 1'b0;
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'hDEADBEEF; alu_high = 1'b0;
    #1;
    chk("alu_nostall", 32'(alu_stall), 32'd0);
    tick;
    chk("alu_we", 32'(we), 32'd1);
    chk("alu_addr", 32'(addr_d), 32'd3);
    chk("alu_data", data_d, 32'hDEADBEEF);
    chk("alu_wehi0", 32'(we_high), 32'd0);
    alu_high = 1'b1; alu_data = 32'h0000ABCD;
    tick;
    chk("alu_wehi1", 32'(we_high), 32'd1);
    chk("alu_data_hi", data_d, 32'h0000ABCD);
    chk("alu_we_hi", 32'(we), 32'd1);
    alu_high = 1'b0; alu_addr = 4'd5; alu_data = 32'h12345678;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_we", 32'(we), 32'd0);
    chk("mid_rst_addr", 32'(addr_d), 32'd0);
    chk("mid_rst_data", data_d, 32'd0);
    chk("mid_rst_wehi", 32'(we_high), 32'd0);
    tick;
    chk("held_rst_we", 32'(we), 32'd0);
    alu_valid = 1'b0;
    reset = 1'b0;
    tick;
    chk("post_rst_we", 32'(we), 32'd0);
    chk("post_rst_addr", 32'(addr_d), 32'd0);
    alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'h11;
    mu_valid = 1'b1; mu_addr = 4'd7; mu_data = 32'h1;
    tick;
    mu_addr = 4'd8; mu_data = 32'h2;
    tick;
    mu_valid = 1'b0; alu_valid = 1'b0; addr_a = 4'd7; addr_b = 4'd8;
    #1;
    chk("drain_ready0", 32'(mu_ready), 32'd0);
    chk("drain_pend_a", 32'(pending_a), 32'd1);
    chk("drain_pend_b", 32'(pending_b), 32'd1);
    chk("drain_nostall", 32'(alu_stall), 32'd0);
    chk("drain_alu_addr", 32'(addr_d), 32'd1);
    tick;
    chk("drain1_we", 32'(we), 32'd1);
    chk("drain1_addr", 32'(addr_d), 32'd7);
    chk("drain1_data", data_d, 32'h1);
    chk("drain1_pend_a", 32'(pending_a), 32'd0);
    chk("drain1_pend_b", 32'(pending_b), 32'd1);
    chk("drain1_ready", 32'(mu_ready), 32'd1);
    tick;
    chk("drain2_we", 32'(we), 32'd1);
    chk("drain2_addr", 32'(addr_d), 32'd8);
    chk("drain2_data", data_d, 32'h2);
    chk("drain2_pend_b", 32'(pending_b), 32'd0);
    tick;
    chk("drain3_we", 32'(we), 32'd0);
    chk("drain3_hold", 32'(addr_d), 32'd8);
    alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'h11;
    mu_valid = 1'b1; mu_addr = 4'd10; mu_data = 32'hA;
    tick;
    mu_addr = 4'd9; mu_data = 32'h9;
    #1;
    chk("fill_nostall", 32'(alu_stall), 32'd0);
    tick;
    mu_valid = 1'b0; alu_addr = 4'd9; alu_data = 32'h99;
    #1;
    chk("full_stall", 32'(alu_stall), 32'd1);
    tick;
    chk("full1_addr", 32'(addr_d), 32'd10);
    chk("full1_data", data_d, 32'hA);
    chk("full1_we", 32'(we), 32'd1);
    chk("full_waw_stall", 32'(alu_stall), 32'd1);
    tick;
    chk("full2_addr", 32'(addr_d), 32'd9);
    chk("full2_data", data_d, 32'h9);
    chk("full2_nostall", 32'(alu_stall), 32'd0);
    tick;
    chk("full3_addr", 32'(addr_d), 32'd9);
    chk("full3_data", data_d, 32'h99);
    chk("full3_we", 32'(we), 32'd1);
`ifdef WB_ARBITER_STATS_EN
    chk("stall_count2", stall_count, 32'd2);
`endif
    alu_addr = 4'd1; alu_data = 32'h11;
    mu_valid = 1'b1; mu_addr = 4'd4; mu_data = 32'hAAAA0000;
    tick;
    mu_valid = 1'b0; alu_addr = 4'd4; alu_data = 32'h5555; addr_a = 4'd4;
    #1;
    chk("waw_stall", 32'(alu_stall), 32'd1);
    chk("waw_pend", 32'(pending_a), 32'd1);
    tick;
    chk("waw1_addr", 32'(addr_d), 32'd4);
    chk("waw1_data", data_d, 32'hAAAA0000);
    chk("waw1_nostall", 32'(alu_stall), 32'd0);
    chk("waw1_pend", 32'(pending_a), 32'd0);
    tick;
    chk("waw2_data", data_d, 32'h5555);
    chk("waw2_we", 32'(we), 32'd1);
    alu_valid = 1'b0;
    tick;
    chk("waw3_we", 32'(we), 32'd0);
    chk("waw3_hold", data_d, 32'h5555);
`ifdef WB_ARBITER_STATS_EN
    chk("stall_count3", stall_count, 32'd3);
`endif
    alu_valid = 1'b1; alu_addr = 4'd0; alu_data = 32'hE;
    mu_valid = 1'b1; mu_addr = 4'd0; mu_data = 32'hF; addr_a = 4'd0;
    tick;
    alu_valid = 1'b0; mu_valid = 1'b0;
    #1;
    chk("r0_alu_we", 32'(we), 32'd0);
    chk("r0_alu_addr", 32'(addr_d), 32'd0);
    chk("r0_pend", 32'(pending_a), 32'd0);
    chk("r0_ready", 32'(mu_ready), 32'd1);
    tick;
    chk("r0_fifo_we", 32'(we), 32'd0);
    chk("r0_fifo_data", data_d, 32'hF);
    tick;
    chk("r0_idle_we", 32'(we), 32'd0);
    chk("r0_empty_ready", 32'(mu_ready), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter directly upstream of the CPU register bank write port.
- Merges two producers onto the bank's single write port (addr_d, data_d, we, we_high):
  - the in-order ALU/pipeline result stream;
  - a variable-latency unit (memory load / multiply-divide) that completes out of band.
- Buffers slow-unit results in a small FIFO and flags pending destinations so decode can stall on RAW/WAW hazards.

Parameters:
- DEPTH, 2, slow-unit FIFO entries; power of two, >= 2.
- PTR_W, 1, log2(DEPTH); FIFO pointer width.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-high reset.
- alu_valid, input, 1, ALU result present this cycle.
- alu_addr, input, 4, ALU destination register.
- alu_data, input, 32, ALU result.
- alu_high, input, 1, write upper half only; low 16 bits of alu_data go to the top half of the register.
- alu_stall, output, 1, combinational; ALU result not accepted this cycle, producer holds it.
- mu_valid, input, 1, slow-unit result offered.
- mu_ready, output, 1, combinational; FIFO not full.
- mu_addr, input, 4, slow-unit destination register.
- mu_data, input, 32, slow-unit result.
- addr_a, input, 4, decode query address A.
- addr_b, input, 4, decode query address B.
- pending_a, output, 1, combinational; addr_a != 0 and addr_a matches a valid FIFO entry.
- pending_b, output, 1, same rule as pending_a, for addr_b.
- addr_d, output, 4, register bank write address; registered.
- data_d, output, 32, register bank write data; registered.
- we, output, 1, register bank write enable; registered.
- we_high, output, 1, register bank upper-half-only write; registered.

Behaviour:
- Reset (async, immediate): FIFO emptied (rd_ptr = wr_ptr = 0, count = 0); addr_d = 0, data_d = 0, we = 0, we_high = 0.
  - Outputs read 0 while reset is held.
  - An in-flight result is discarded.
- FIFO push: mu_valid && mu_ready at the clock edge.
  - mu_ready = (count != DEPTH).
  - Push while full is impossible by the handshake.
- Selection, evaluated combinationally each cycle:
  - sel_fifo = count != 0 && (!alu_valid || count == DEPTH || alu_waw).
  - alu_waw = alu_valid && alu_addr != 0 && alu_addr matches any valid FIFO entry.
  - alu_stall = alu_valid && sel_fifo.
  - ALU wins when alu_valid and not stalled; the FIFO head drains only on idle ALU cycles, full FIFO, or WAW.
- Write output register, updated at the clock edge:
  - If sel_fifo: pop the head; addr_d = head addr, data_d = head data, we_high = 0.
  - Else if alu_valid: addr_d = alu_addr, data_d = alu_data, we_high = alu_high.
  - Else: we = 0; addr_d, data_d and we_high hold their previous values.
  - we = 1 only when the selected address != 0. Writes to r0 are consumed (popped or accepted) but suppressed.
  - Latency: 1 cycle from acceptance to we on the bank port. The bank's internal write-through covers the read in the same cycle.
- Simultaneous push and pop: count unchanged; the pointers advance independently, so a full FIFO can pop and push in the same cycle only if mu_ready was already high (it is not when full), so this case is excluded.
- Pointer wrap: modulo DEPTH. Count is PTR_W+1 bits to distinguish full from empty.
- pending_a / pending_b:
  - Reflect FIFO contents before this cycle's pop and push.
  - The entry currently held in the output register is not pending; it is visible via bank forwarding.
- Ordering: entries leave the FIFO in push order. An ALU write never overtakes an older FIFO write to the same register (alu_waw rule).

Optional Feature:
- Macro: WB_ARBITER_STATS_EN.
- Defined:
  - Adds output stall_count[31:0], reset to 0.
  - Increments by 1 on every cycle with alu_stall = 1.
  - Saturates at 32'hFFFFFFFF.
- Undefined: the port and counter are absent; no other behaviour changes.

Test Plan:
- Reset mid-write: alu_valid, alu_addr = 5, alu_data = 32'h12345678, assert reset before the edge -> we = 0, addr_d = 0 immediately; no write after release.
- ALU only: alu_valid, alu_addr = 3, alu_data = 32'hDEADBEEF, alu_high = 0 -> next cycle we = 1, addr_d = 3, data_d = 32'hDEADBEEF, we_high = 0. Repeat with alu_high = 1, data 32'h0000ABCD -> we_high = 1.
- FIFO drain on idle: push mu_addr = 7 data 32'h1 and mu_addr = 8 data 32'h2 with ALU busy -> mu_ready = 0 after 2 pushes, pending_a = 1 for addr_a = 7. Drop alu_valid -> writes r7 = 1 then r8 = 2 on consecutive cycles; pending clears.
- Full-FIFO priority: FIFO full (DEPTH = 2), alu_valid = 1, alu_addr = 9 -> alu_stall = 1 for 2 cycles while both entries write. ALU r9 write follows in cycle 3. Stats build: stall_count = 2.
- WAW: FIFO holds r4 = 32'hAAAA0000, ALU offers r4 = 32'h5555 -> alu_stall = 1; r4 FIFO write first, then ALU write. Final r4 = 32'h5555.
- r0 writes: mu push addr 0 and ALU addr 0 -> both consumed, we never asserted, pending_a = 0 for addr_a = 0.
